// File: rtl/counter_sched.sv
// counter_sched: two-requester round-robin interval counter with abort and one-cycle done pulse
module counter_sched #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] limit0,
    input  logic [WIDTH-1:0] limit1,
    input  logic             abort,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic [WIDTH-1:0] Q,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_n;
    logic [1:0]       gnt_n, done_n;
    logic [WIDTH-1:0] q_n, lim, lim_n;
    logic             ptr, ptr_n, sel;
    always_comb sel = (req == 2'b11) ? ptr : req[1];
    always_comb busy = (state != IDLE);
    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        done_n  = 2'b00;
        q_n     = Q;
        lim_n   = lim;
        ptr_n   = ptr;
        case (state)
            IDLE: if (|req) begin
                state_n = RUN;
                gnt_n   = sel ? 2'b10 : 2'b01;
                lim_n   = sel ? limit1 : limit0;
                q_n     = '0;
            end
            RUN: if (abort) begin
                state_n = IDLE;
                gnt_n   = 2'b00;
                q_n     = '0;
                ptr_n   = ~gnt[1];
            end else if (Q == lim) begin
                state_n = DONE;
                done_n  = gnt;
            end else begin
                q_n = Q + 1'b1;
            end
            DONE: begin
                state_n = IDLE;
                gnt_n   = 2'b00;
                q_n     = '0;
                ptr_n   = ~gnt[1];
            end
            default: begin
                state_n = IDLE;
                gnt_n   = 2'b00;
                q_n     = '0;
            end
        endcase
    end
    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
            gnt   <= 2'b00;
            done  <= 2'b00;
            Q     <= '0;
            lim   <= '0;
            ptr   <= 1'b0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            done  <= done_n;
            Q     <= q_n;
            lim   <= lim_n;
            ptr   <= ptr_n;
        end
    end
endmodule

// File: tb/tb_counter_sched.sv
// tb_counter_sched: randomized scoreboard bench against an interval-offset reference model
module tb_counter_sched;
    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic [1:0] req = 2'b00;
    logic [3:0] limit0 = 4'd0, limit1 = 4'd0;
    logic       abort = 1'b0;
    logic [1:0] gnt, done;
    logic [3:0] Q;
    logic       busy;

    typedef struct packed {
        logic [1:0] gnt;
        logic [1:0] done;
        logic [3:0] q;
        logic       busy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;

    bit   m_act = 0;
    bit   m_g = 0;
    bit   m_ptr = 0;
    int   m_lim = 0;
    int   m_k = 0;

    counter_sched #(.WIDTH(4)) dut (
        .clock(clock), .clear(clear), .req(req), .limit0(limit0), .limit1(limit1),
        .abort(abort), .gnt(gnt), .done(done), .Q(Q), .busy(busy)
    );

    always #5 clock = ~clock;

    // Model: an interval is (winner, limit, offset since grant); outputs follow from the offset alone.
    task automatic step(input logic c, input logic [1:0] r, input logic [3:0] a0, input logic [3:0] a1, input logic ab);
        exp_t e;
        @(negedge clock);
        clear = c; req = r; limit0 = a0; limit1 = a1; abort = ab;
        @(posedge clock);
        if (c) begin
            m_act = 0;
            m_ptr = 0;
        end else if (!m_act) begin
            if (r != 2'b00) begin
                m_g   = (r == 2'b11) ? m_ptr : (r == 2'b10);
                m_lim = m_g ? int'(a1) : int'(a0);
                m_k   = 0;
                m_act = 1;
            end
        end else if ((m_k <= m_lim && ab) || m_k == m_lim + 1) begin
            m_act = 0;
            m_ptr = !m_g;
        end else begin
            m_k++;
        end
        e = '0;
        if (m_act) begin
            e.gnt  = m_g ? 2'b10 : 2'b01;
            e.busy = 1'b1;
            e.q    = 4'((m_k > m_lim) ? m_lim : m_k);
            e.done = (m_k == m_lim + 1) ? e.gnt : 2'b00;
        end
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cyc++;
                checks++;
                if ({gnt, done, Q, busy} !== e) begin
                    fails++;
                    $display("FAIL outputs cycle %0d: got gnt=%b done=%b Q=%0d busy=%b, required gnt=%b done=%b Q=%0d busy=%b",
                             cyc, gnt, done, Q, busy, e.gnt, e.done, e.q, e.busy);
                end
                checks++;
                if (!$onehot0(gnt) || (done & ~gnt) != 2'b00) begin
                    fails++;
                    $display("FAIL onehot cycle %0d: got gnt=%b done=%b, required one-hot-or-zero with done under gnt",
                             cyc, gnt, done);
                end
            end
        end
    end

    initial begin : driver
        step(1, 2'b00, 4'd0, 4'd0, 0);
        step(1, 2'b11, 4'd7, 4'd7, 1);
        step(0, 2'b01, 4'd3, 4'd0, 0);
        for (int i = 0; i < 7; i++) step(0, 2'b00, 4'd9, 4'd9, 0);
        for (int i = 0; i < 24; i++) step(0, 2'b11, 4'd2, 4'd1, 0);
        step(1, 2'b00, 4'd0, 4'd0, 0);
        step(0, 2'b10, 4'd5, 4'd0, 0);
        for (int i = 0; i < 4; i++) step(0, 2'b00, 4'd0, 4'd0, 0);
        step(0, 2'b01, 4'd15, 4'd0, 0);
        for (int i = 0; i < 5; i++) step(0, 2'b00, 4'd0, 4'd0, 0);
        step(0, 2'b00, 4'd0, 4'd0, 1);
        step(0, 2'b11, 4'd3, 4'd2, 0);
        for (int i = 0; i < 6; i++) step(0, 2'b00, 4'd0, 4'd0, 0);
        step(0, 2'b01, 4'd9, 4'd0, 0);
        for (int i = 0; i < 6; i++) step(0, 2'b01, 4'd1, 4'd1, 0);
        step(1, 2'b01, 4'd9, 4'd9, 0);
        step(0, 2'b01, 4'd4, 4'd0, 0);
        for (int i = 0; i < 8; i++) step(0, 2'b00, 4'd0, 4'd0, 0);
        step(0, 2'b01, 4'd15, 4'd15, 0);
        for (int i = 0; i < 19; i++) step(0, 2'b00, 4'd0, 4'd0, 0);
        for (int i = 0; i < 3000; i++) begin
            logic       c, ab;
            logic [1:0] r;
            logic [3:0] a0, a1;
            c  = ($urandom_range(0, 63) == 0);
            ab = ($urandom_range(0, 11) == 0);
            r  = 2'($urandom_range(0, 3));
            a0 = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            a1 = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            step(c, r, a0, a1, ab);
        end
        @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending entries, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/counter_sched.md
COUNTER_SCHED -- requirements
Module: counter_sched

Interface
REQ-001 Parameter: WIDTH, default 4, bit width of the shared count register and of each limit.
REQ-002 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: clear  input  1  reset; synchronous, active-high.
REQ-004 Port: req  input  2  per-requester interval request; bit i belongs to requester i.
REQ-005 Port: limit0  input  WIDTH  terminal count for requester 0; sampled only at grant.
REQ-006 Port: limit1  input  WIDTH  terminal count for requester 1; sampled only at grant.
REQ-007 Port: abort  input  1  terminates the current interval without completion.
REQ-008 Port: gnt  output  2  one-hot grant; all zero when no interval is active.
REQ-009 Port: done  output  2  one-cycle completion pulse to the served requester.
REQ-010 Port: Q  output  WIDTH  shared count value.
REQ-011 Port: busy  output  1  high in states RUN and DONE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE with req==00: remain in IDLE; Q, gnt and done hold 0.
REQ-014 IDLE with any req bit set: on the next edge go to RUN, set gnt one-hot to the selected requester, latch its limit into an internal register, and set Q=0.
REQ-015 Selection: a single active request wins outright; with req==11, the requester named by a 1-bit round-robin pointer wins.
REQ-016 RUN with Q != latched limit and abort==0: Q increments by 1 per cycle; gnt holds.
REQ-017 RUN with Q == latched limit and abort==0: on the next edge go to DONE with done[g]=1 for the granted g; Q holds.
REQ-018 DONE: the state lasts exactly one cycle; on the next edge go to IDLE with gnt=0, done=0 and Q=0.
REQ-019 Timing: grant edge t0 gives Q=k at t0+k; done is high only in cycle t0+L+1; gnt is high for L+2 cycles, where L is the latched limit.
REQ-020 Limit 0: RUN lasts one cycle with Q=0, then DONE.
REQ-021 Q SHALL never exceed the latched limit and SHALL never wrap; limit = 2^WIDTH-1 is legal.
REQ-022 abort in RUN (takes precedence over the terminal match): on the next edge go to IDLE with gnt=0, Q=0 and no done pulse; abort is ignored in IDLE and DONE.
REQ-023 Pointer update: on leaving RUN or DONE toward IDLE, the pointer SHALL become the requester not just served, whether or not the interval completed.
REQ-024 Changes to req, limit0 or limit1 during RUN/DONE SHALL have no effect on the current interval.
REQ-025 Inter-grant gap: at least one IDLE cycle between consecutive grants; a request held through DONE is granted on the edge after IDLE samples it.
REQ-026 gnt and done SHALL always be one-hot or zero; done[i] SHALL only assert while gnt[i]=1.

Reset
REQ-027 clear=1 at a rising edge SHALL force state=IDLE, Q=0, gnt=00, done=00, busy=0 and pointer=0, overriding all other inputs.
REQ-028 clear asserted mid-RUN or in DONE SHALL suppress any pending done pulse; operation resumes on the first edge after clear deasserts.

Verification
REQ-029 Apply clear, then req=01 with limit0=3 -> gnt=01, Q sequence 0,1,2,3, done=01 for one cycle at t0+4, then IDLE with Q=0.
REQ-030 Hold req=11 (limit0=2, limit1=1) continuously -> grants alternate 01,10,01,... with one IDLE cycle between them; each done pulse goes only to the granted requester.
REQ-031 Grant requester 1 with limit1=0 -> one RUN cycle at Q=0, done=10 at t0+1, gnt high for exactly 2 cycles.
REQ-032 limit0=15: start, then assert abort when Q=5 -> next cycle gnt=00, Q=0, no done; a subsequent req=11 grants requester 1.
REQ-033 Assert clear when Q=6 during RUN (limit=9) -> next cycle all outputs 0 with no done; after clear releases, req=01 restarts from Q=0.
REQ-034 Run limit=15 to completion -> Q reaches 15 without wrapping and done fires at t0+16.
